gemm_loader_fsm: RTL and testbench
==================================

// Module: gemm_loader_fsm
// PURPOSE
//  Parametrised successor to the 4-FIFO GEMM loader: drains NUM_CH first-word-fall-through GEMM FIFOs into the
//  systolic array's weight/input bus and partial-sum bus. Arbitrates between channels; sequences weight reloads
//  behind array drain; stalls input/partial traffic on output back-pressure. Sits between scratchpad GEMM FIFOs and the array.
// PARAMETERS
//  NUM_CH        4   number of GEMM FIFO channels (>=1)
//  ROWS          4   array rows; weight load length
//  BITS_PER_ROW  64  row payload width
//  ROW_S_W       $clog2(ROWS)  row-select width (derived)
//  ENTRY_W       BITS_PER_ROW+ROW_S_W+3  FIFO entry width (derived)
// PORTS
//  clk                   in   1                    clock, rising edge
//  rst                   in   1                    asynchronous, active-high reset
//  fifo_rdata            in   NUM_CH*ENTRY_W       head entry of each FIFO; ch i at [i*ENTRY_W +: ENTRY_W]
//  fifo_empty            in   NUM_CH               per-channel empty
//  fifo_ren              out  NUM_CH               per-channel pop, combinational, onehot0
//  drained               in   1                    array has no in-flight work
//  fifo_has_space        in   1                    downstream output FIFO can accept one row
//  new_weight            in   1                    level: weight reload pending; blocks input/partial issue
//  weight_input_data     out  BITS_PER_ROW         weight or input row (registered)
//  weight_input_row_sel  out  ROW_S_W              row index for weight_input_data
//  partial_sum_data      out  BITS_PER_ROW         partial-sum row (registered)
//  partial_sum_row_sel   out  ROW_S_W              row index for partial_sum_data
//  input_enable          out  1                    1-cycle strobe: input row valid
//  weight_enable         out  1                    1-cycle strobe: weight row valid
//  partial_enable        out  1                    1-cycle strobe: partial row valid
//  weight_done           out  1                    1-cycle pulse: weight load finished
//  busy                  out  1                    state != IDLE
//  err_illegal           out  1                    sticky: reserved kind popped
// BEHAVIOUR
//  Entry = {data[BITS_PER_ROW], row_sel[ROW_S_W], last, kind[1:0]}; kind 00 input, 01 weight, 10 partial, 11 reserved.
//  Reset: all outputs 0, state IDLE, rr pointer 0, row counter 0. Reset mid-load abandons the load; FIFOs untouched.
//  At most one pop per cycle. Pop in cycle N -> data/row_sel/enable registered, visible cycle N+1 (latency 1).
//  States:
//   IDLE   : grant = arbiter over non-empty channels whose head is issuable; none -> stay.
//            head weight: drained ? pop, ->WLOAD : ->WWAIT (channel locked). input/partial: issuable iff
//            fifo_has_space & !new_weight; pop, stay IDLE. reserved: pop, drop, set err_illegal, no strobe.
//   WWAIT  : locked channel; when drained=1 -> WLOAD (no pop this cycle).
//   WLOAD  : locked channel; each cycle !empty -> pop, weight_enable next cycle, row_cnt++; empty -> stall, no strobe.
//            End when popped entry has last=1 or row_cnt==ROWS-1 -> weight_done pulse (with final strobe), ->IDLE.
//            Non-weight head while in WLOAD -> ends load early: no pop, weight_done, ->IDLE.
//  First weight row issued from IDLE (drained) counts as row 0.
//  fifo_has_space=0: no input/partial pops; weight traffic unaffected. drained is ignored outside weight issue.
//  Enables are 0 in any cycle with no issue; data regs hold last value.
//  row_sel passed through unmodified; row_cnt wraps to 0 on load end.
// CONFIGURATION
//  GEMM_LOADER_RR_EN defined: round-robin arbitration; pointer moves to granted+1 (mod NUM_CH) after each IDLE grant.
//  Not defined: fixed priority, lowest channel index wins; no pointer state.
// TESTING
//  1 ch0 input kind, row_sel=2, has_space=1 -> fifo_ren[0] cycle N; input_enable=1, row_sel=2 cycle N+1.
//  2 ch1 4 weight rows, drained=0 for 3 cycles then 1 -> WWAIT 3 cycles, 4 weight_enable strobes, weight_done with 4th.
//  3 weight rows, 2nd has last=1 -> 2 strobes, weight_done, IDLE; row_cnt 0.
//  4 all 4 ch hold input, RR_EN -> grants 0,1,2,3,0; without RR_EN -> ch0 drained first.
//  5 has_space=0 with input heads -> fifo_ren=0, no strobes; raise -> issue next cycle.
//  6 reserved kind popped -> no strobe, err_illegal=1 until rst; rst mid-WLOAD -> IDLE, outputs 0.

Source files
------------

// File: rtl/gemm_loader_fsm.sv
// GEMM loader: drains NUM_CH first-word-fall-through FIFOs into the systolic array's weight/input and partial-sum buses.
// Define GEMM_LOADER_RR_EN for round-robin arbitration; otherwise the lowest non-blocked channel wins.
module gemm_loader_fsm #(
  parameter int NUM_CH       = 4,
  parameter int ROWS         = 4,
  parameter int BITS_PER_ROW = 64,
  parameter int ROW_S_W      = $clog2(ROWS),
  parameter int ENTRY_W      = BITS_PER_ROW + ROW_S_W + 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*ENTRY_W-1:0]   fifo_rdata,
  input  logic [NUM_CH-1:0]           fifo_empty,
  output logic [NUM_CH-1:0]           fifo_ren,
  input  logic                        drained,
  input  logic                        fifo_has_space,
  input  logic                        new_weight,
  output logic [BITS_PER_ROW-1:0]     weight_input_data,
  output logic [ROW_S_W-1:0]          weight_input_row_sel,
  output logic [BITS_PER_ROW-1:0]     partial_sum_data,
  output logic [ROW_S_W-1:0]          partial_sum_row_sel,
  output logic                        input_enable,
  output logic                        weight_enable,
  output logic                        partial_enable,
  output logic                        weight_done,
  output logic                        busy,
  output logic                        err_illegal
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WWAIT = 2'd1;
  localparam logic [1:0] ST_WLOAD = 2'd2;

  localparam logic [1:0] K_INPUT   = 2'b00;
  localparam logic [1:0] K_WEIGHT  = 2'b01;
  localparam logic [1:0] K_PARTIAL = 2'b10;
  localparam logic [1:0] K_RSVD    = 2'b11;

  logic [1:0]              state, state_nxt;
  logic [CH_W-1:0]         lock_ch, lock_nxt;
  logic [ROW_S_W-1:0]      row_cnt, row_cnt_nxt;
  logic [ENTRY_W-1:0]      head [NUM_CH];
  logic [NUM_CH-1:0]       eligible;
  logic                    grant_vld;
  logic [CH_W-1:0]         grant_ch, sel_ch;
  logic [ENTRY_W-1:0]      sel_entry;
  logic [1:0]              sel_kind;
  logic                    sel_last;
  logic [ROW_S_W-1:0]      sel_rsel;
  logic [BITS_PER_ROW-1:0] sel_data;
  logic                    pop, in_stb, w_stb, p_stb, done_nxt, err_set, ptr_adv;

  // Weights and reserved entries never wait on output space; input/partial rows do.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_head
    assign head[i]     = fifo_rdata[i*ENTRY_W +: ENTRY_W];
    assign eligible[i] = !fifo_empty[i] &&
                         ((head[i][1:0] == K_WEIGHT) || (head[i][1:0] == K_RSVD) ||
                          (fifo_has_space && !new_weight));
  end

`ifdef GEMM_LOADER_RR_EN
  logic [CH_W-1:0] rr_ptr;

  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (eligible[idx]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (ptr_adv)
      rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(k);
      end
    end
  end
`endif

  function automatic logic load_end(input logic last, input logic [ROW_S_W-1:0] cnt);
    return last || (cnt == ROW_S_W'(ROWS - 1));
  endfunction

  assign sel_ch    = (state == ST_IDLE) ? grant_ch : lock_ch;
  assign sel_entry = head[sel_ch];
  assign sel_kind  = sel_entry[1:0];
  assign sel_last  = sel_entry[2];
  assign sel_rsel  = sel_entry[3 +: ROW_S_W];
  assign sel_data  = sel_entry[3 + ROW_S_W +: BITS_PER_ROW];

  always_comb begin
    state_nxt   = state;
    lock_nxt    = lock_ch;
    row_cnt_nxt = row_cnt;
    pop         = 1'b0;
    in_stb      = 1'b0;
    w_stb       = 1'b0;
    p_stb       = 1'b0;
    done_nxt    = 1'b0;
    err_set     = 1'b0;
    ptr_adv     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          ptr_adv = 1'b1;
          case (sel_kind)
            K_WEIGHT: begin
              lock_nxt = grant_ch;
              if (drained) begin
                pop   = 1'b1;
                w_stb = 1'b1;
                if (load_end(sel_last, row_cnt)) begin
                  done_nxt    = 1'b1;
                  row_cnt_nxt = '0;
                end else begin
                  row_cnt_nxt = row_cnt + 1'b1;
                  state_nxt   = ST_WLOAD;
                end
              end else begin
                state_nxt = ST_WWAIT;
              end
            end
            K_RSVD: begin
              pop     = 1'b1;
              err_set = 1'b1;
            end
            K_INPUT: begin
              pop    = 1'b1;
              in_stb = 1'b1;
            end
            default: begin
              pop   = 1'b1;
              p_stb = 1'b1;
            end
          endcase
        end
      end
      ST_WWAIT: begin
        if (drained) state_nxt = ST_WLOAD;
      end
      ST_WLOAD: begin
        if (!fifo_empty[lock_ch]) begin
          if (sel_kind == K_WEIGHT) begin
            pop   = 1'b1;
            w_stb = 1'b1;
            if (load_end(sel_last, row_cnt)) begin
              done_nxt    = 1'b1;
              row_cnt_nxt = '0;
              state_nxt   = ST_IDLE;
            end else begin
              row_cnt_nxt = row_cnt + 1'b1;
            end
          end else begin
            // A non-weight head means the producer cut the load short.
            done_nxt    = 1'b1;
            row_cnt_nxt = '0;
            state_nxt   = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A pop seen while reset is held would consume an entry the reset abandons.
  always_comb begin
    fifo_ren = '0;
    if (pop && !rst) fifo_ren[sel_ch] = 1'b1;
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      lock_ch              <= '0;
      row_cnt              <= '0;
      input_enable         <= 1'b0;
      weight_enable        <= 1'b0;
      partial_enable       <= 1'b0;
      weight_done          <= 1'b0;
      err_illegal          <= 1'b0;
      weight_input_data    <= '0;
      weight_input_row_sel <= '0;
      partial_sum_data     <= '0;
      partial_sum_row_sel  <= '0;
    end else begin
      state          <= state_nxt;
      lock_ch        <= lock_nxt;
      row_cnt        <= row_cnt_nxt;
      input_enable   <= in_stb;
      weight_enable  <= w_stb;
      partial_enable <= p_stb;
      weight_done    <= done_nxt;
      if (err_set) err_illegal <= 1'b1;
      if (in_stb || w_stb) begin
        weight_input_data    <= sel_data;
        weight_input_row_sel <= sel_rsel;
      end
      if (p_stb) begin
        partial_sum_data    <= sel_data;
        partial_sum_row_sel <= sel_rsel;
      end
    end
  end
endmodule

// File: tb/tb_gemm_loader_fsm.sv
// Directed bench for gemm_loader_fsm: behavioural FWFT FIFOs feed the DUT, expected values are hand-derived.
module tb_gemm_loader_fsm;
  localparam int NUM_CH = 4;
  localparam int ROWS   = 4;
  localparam int BITS   = 64;
  localparam int RSW    = 2;
  localparam int EW     = BITS + RSW + 3;
  localparam int DEPTH  = 64;

  localparam logic [1:0] K_IN = 2'b00;
  localparam logic [1:0] K_W  = 2'b01;
  localparam logic [1:0] K_P  = 2'b10;
  localparam logic [1:0] K_R  = 2'b11;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_CH*EW-1:0]   fifo_rdata;
  logic [NUM_CH-1:0]      fifo_empty;
  logic [NUM_CH-1:0]      fifo_ren;
  logic                   drained = 1'b1;
  logic                   fifo_has_space = 1'b1;
  logic                   new_weight = 1'b0;
  logic [BITS-1:0]        weight_input_data;
  logic [RSW-1:0]         weight_input_row_sel;
  logic [BITS-1:0]        partial_sum_data;
  logic [RSW-1:0]         partial_sum_row_sel;
  logic                   input_enable, weight_enable, partial_enable;
  logic                   weight_done, busy, err_illegal;

  logic [EW-1:0] mem [NUM_CH][DEPTH];
  int            rd [NUM_CH] = '{default: 0};
  int            wr [NUM_CH] = '{default: 0};
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  gemm_loader_fsm #(.NUM_CH(NUM_CH), .ROWS(ROWS), .BITS_PER_ROW(BITS)) dut (
    .clk(clk), .rst(rst), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
    .drained(drained), .fifo_has_space(fifo_has_space), .new_weight(new_weight),
    .weight_input_data(weight_input_data), .weight_input_row_sel(weight_input_row_sel),
    .partial_sum_data(partial_sum_data), .partial_sum_row_sel(partial_sum_row_sel),
    .input_enable(input_enable), .weight_enable(weight_enable), .partial_enable(partial_enable),
    .weight_done(weight_done), .busy(busy), .err_illegal(err_illegal)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
    assign fifo_rdata[i*EW +: EW] = mem[i][rd[i]];
    assign fifo_empty[i]          = (rd[i] == wr[i]);
  end

  always @(posedge clk)
    for (int i = 0; i < NUM_CH; i++)
      if (fifo_ren[i]) rd[i] <= rd[i] + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [BITS-1:0] d, input logic [RSW-1:0] rs,
                                       input logic last, input logic [1:0] kind);
    return {d, rs, last, kind};
  endfunction

  task automatic push(input int ch, input logic [EW-1:0] e);
    mem[ch][wr[ch]] = e;
    wr[ch] = wr[ch] + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ie"}, 64'(input_enable), 64'd0);
    chk({tag, "_we"}, 64'(weight_enable), 64'd0);
    chk({tag, "_pe"}, 64'(partial_enable), 64'd0);
    chk({tag, "_wd"}, 64'(weight_done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int exp_ch [8];

    tick();
    tick();
    // Reset state
    check_idle_outputs("rst");
    chk("rst_err", 64'(err_illegal), 64'd0);
    chk("rst_wid", weight_input_data, 64'd0);
    chk("rst_ren", 64'(fifo_ren), 64'd0);
    rst = 1'b0;
    tick();

    // T1: single input row on ch0, latency 1
    push(0, mk(64'hA5A5_0000_1234_5678, 2'd2, 1'b0, K_IN));
    #1;
    chk("t1_ren", 64'(fifo_ren), 64'h1);
    tick();
    chk("t1_ie", 64'(input_enable), 64'd1);
    chk("t1_data", weight_input_data, 64'hA5A5_0000_1234_5678);
    chk("t1_rsel", 64'(weight_input_row_sel), 64'd2);
    chk("t1_we", 64'(weight_enable), 64'd0);
    tick();
    chk("t1_ie_off", 64'(input_enable), 64'd0);
    chk("t1_hold", weight_input_data, 64'hA5A5_0000_1234_5678);

    // T2: ch1 weight load waits for drain, 4 rows end on row count
    drained = 1'b0;
    for (int r = 0; r < 4; r++) push(1, mk(64'h1111_0000_0000_0000 + 64'(r), 2'(r), 1'b0, K_W));
    #1;
    chk("t2_ren_idle", 64'(fifo_ren), 64'd0);
    tick();
    chk("t2_busy_wwait", 64'(busy), 64'd1);
    for (int c = 0; c < 2; c++) begin
      chk("t2_ren_wwait", 64'(fifo_ren), 64'd0);
      tick();
    end
    drained = 1'b1;
    #1;
    chk("t2_ren_wake", 64'(fifo_ren), 64'd0);
    tick();
    chk("t2_we_wake", 64'(weight_enable), 64'd0);
    for (int r = 0; r < 4; r++) begin
      chk("t2_ren", 64'(fifo_ren), 64'h2);
      tick();
      chk("t2_we", 64'(weight_enable), 64'd1);
      chk("t2_data", weight_input_data, 64'h1111_0000_0000_0000 + 64'(r));
      chk("t2_rsel", 64'(weight_input_row_sel), 64'(r));
      chk("t2_done", 64'(weight_done), (r == 3) ? 64'd1 : 64'd0);
    end
    chk("t2_busy_end", 64'(busy), 64'd0);
    tick();
    chk("t2_we_off", 64'(weight_enable), 64'd0);
    chk("t2_done_off", 64'(weight_done), 64'd0);

    // T3: load cut short by last=1 on the second row
    push(2, mk(64'h2222_0000_0000_0000, 2'd0, 1'b0, K_W));
    push(2, mk(64'h2222_0000_0000_0001, 2'd1, 1'b1, K_W));
    #1;
    chk("t3_ren0", 64'(fifo_ren), 64'h4);
    tick();
    chk("t3_we0", 64'(weight_enable), 64'd1);
    chk("t3_done0", 64'(weight_done), 64'd0);
    chk("t3_busy0", 64'(busy), 64'd1);
    chk("t3_ren1", 64'(fifo_ren), 64'h4);
    tick();
    chk("t3_we1", 64'(weight_enable), 64'd1);
    chk("t3_done1", 64'(weight_done), 64'd1);
    chk("t3_busy1", 64'(busy), 64'd0);
    tick();
    chk("t3_we_off", 64'(weight_enable), 64'd0);

    // T4: arbitration over four input channels, from a fresh pointer
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
`ifdef GEMM_LOADER_RR_EN
    exp_ch = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
    exp_ch = '{0, 0, 1, 1, 2, 2, 3, 3};
`endif
    for (int c = 0; c < NUM_CH; c++)
      for (int n = 0; n < 2; n++)
        push(c, mk(64'h4444_0000_0000_0000 + 64'(c * 16 + n), 2'(c), 1'b0, K_IN));
    #1;
    for (int g = 0; g < 8; g++) begin
      chk("t4_ren", 64'(fifo_ren), 64'(1 << exp_ch[g]));
      tick();
      chk("t4_ie", 64'(input_enable), 64'd1);
      chk("t4_rsel", 64'(weight_input_row_sel), 64'(exp_ch[g]));
    end
    chk("t4_ren_empty", 64'(fifo_ren), 64'd0);
    tick();

    // T5: output back-pressure and pending weight block input/partial
    push(0, mk(64'h5555_0000_0000_00AA, 2'd1, 1'b0, K_IN));
    push(1, mk(64'h5555_0000_0000_00BB, 2'd3, 1'b0, K_P));
    fifo_has_space = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t5_ren_stall", 64'(fifo_ren), 64'd0);
      tick();
      chk("t5_ie_stall", 64'(input_enable), 64'd0);
      chk("t5_pe_stall", 64'(partial_enable), 64'd0);
    end
    fifo_has_space = 1'b1;
    new_weight = 1'b1;
    #1;
    chk("t5_ren_nw", 64'(fifo_ren), 64'd0);
    tick();
    new_weight = 1'b0;
    #1;
    chk("t5_ren_in", 64'(fifo_ren), 64'h1);
    tick();
    chk("t5_ie", 64'(input_enable), 64'd1);
    chk("t5_ren_ps", 64'(fifo_ren), 64'h2);
    tick();
    chk("t5_pe", 64'(partial_enable), 64'd1);
    chk("t5_ie_off", 64'(input_enable), 64'd0);
    chk("t5_psd", partial_sum_data, 64'h5555_0000_0000_00BB);
    chk("t5_psr", 64'(partial_sum_row_sel), 64'd3);
    chk("t5_wid_hold", weight_input_data, 64'h5555_0000_0000_00AA);

    // T6: reserved kind is dropped and flagged
    push(3, mk(64'h6666, 2'd0, 1'b0, K_R));
    #1;
    chk("t6_ren_rsvd", 64'(fifo_ren), 64'h8);
    tick();
    chk("t6_ie", 64'(input_enable), 64'd0);
    chk("t6_we", 64'(weight_enable), 64'd0);
    chk("t6_pe", 64'(partial_enable), 64'd0);
    chk("t6_err", 64'(err_illegal), 64'd1);
    tick();
    chk("t6_err_sticky", 64'(err_illegal), 64'd1);

    // T7: weight load ignores back-pressure; reset mid-load
    fifo_has_space = 1'b0;
    for (int r = 0; r < 4; r++) push(0, mk(64'h7777_0000_0000_0000 + 64'(r), 2'(r), 1'b0, K_W));
    #1;
    chk("t7_ren0", 64'(fifo_ren), 64'h1);
    tick();
    chk("t7_we0", 64'(weight_enable), 64'd1);
    chk("t7_ren1", 64'(fifo_ren), 64'h1);
    tick();
    chk("t7_we1", 64'(weight_enable), 64'd1);
    chk("t7_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("t7_rst");
    chk("t7_err_clr", 64'(err_illegal), 64'd0);
    chk("t7_wid_clr", weight_input_data, 64'd0);
    chk("t7_ren_rst", 64'(fifo_ren), 64'd0);
    rst = 1'b0;
    fifo_has_space = 1'b1;

    // T8: leftover rows start a new load, stall on empty, end early on input head
    tick();
    chk("t8_we0", 64'(weight_enable), 64'd1);
    chk("t8_data0", weight_input_data, 64'h7777_0000_0000_0002);
    tick();
    chk("t8_we1", 64'(weight_enable), 64'd1);
    chk("t8_data1", weight_input_data, 64'h7777_0000_0000_0003);
    chk("t8_done1", 64'(weight_done), 64'd0);
    tick();
    chk("t8_we_stall", 64'(weight_enable), 64'd0);
    chk("t8_busy_stall", 64'(busy), 64'd1);
    push(0, mk(64'h8888, 2'd1, 1'b0, K_IN));
    #1;
    chk("t8_ren_early", 64'(fifo_ren), 64'd0);
    tick();
    chk("t8_done_early", 64'(weight_done), 64'd1);
    chk("t8_we_early", 64'(weight_enable), 64'd0);
    chk("t8_busy_early", 64'(busy), 64'd0);
    chk("t8_ren_in", 64'(fifo_ren), 64'h1);
    tick();
    chk("t8_ie", 64'(input_enable), 64'd1);
    chk("t8_data_in", weight_input_data, 64'h8888);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
